fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage plus IF/DEC pipeline register, directly upstream of the hazard unit.
//  Holds the PC and issues one blocking fetch at a time to the instruction cache.
//  Drives o_stall_cache into the hazard unit while a miss is pending.
//  Obeys stall/flush from the hazard unit; on its own, remembers a branch redirect that lands
//  during a miss, while the hazard unit suppresses flush.
// PARAMETERS
//  ADDR_W    64                     PC / fetch address width
//  INSTR_W   32                     instruction width
//  RESET_PC  {ADDR_W{1'b0}}         PC value after reset
//  NOP_INSTR 32'h0000_0013          bubble encoding (addi x0,x0,0)
// PORTS
//  i_clk             in   1        clock
//  i_arst_n          in   1        asynchronous reset, active low
//  i_stall_fetch     in   1        hazard unit: hold PC
//  i_stall_dec       in   1        hazard unit: hold IF/DEC register
//  i_flush_dec       in   1        hazard unit: load bubble into IF/DEC
//  i_pc_src_exec     in   1        taken branch/jump resolved in EXEC
//  i_pc_target_exec  in   ADDR_W   redirect target
//  o_mem_req         out  1        fetch request (registered)
//  o_mem_addr        out  ADDR_W   fetch address; stable while a miss is pending
//  i_mem_valid       in   1        i_mem_rdata valid this cycle; hit if in the request cycle
//  i_mem_rdata       in   INSTR_W  fetched instruction
//  o_stall_cache     out  1        miss pending; goes to hazard unit i_stall_cache
//  o_instr_dec       out  INSTR_W  IF/DEC instruction
//  o_pc_dec          out  ADDR_W   IF/DEC PC
//  o_pc_plus4_dec    out  ADDR_W   IF/DEC PC+4
//  o_valid_dec       out  1        IF/DEC holds a real instruction
// BEHAVIOUR
//  Reset (async assert; deassert synchronised externally):
//   pc=RESET_PC; state=RUN; redir_pend=0; o_mem_req=0, then 1 from the first clock edge.
//   o_instr_dec=NOP_INSTR; o_pc_dec=0; o_pc_plus4_dec=0; o_valid_dec=0.
//   Reset mid-miss drops the outstanding request silently.
//  o_mem_addr = pc (combinational). Arithmetic: pc+4 wraps modulo 2^ADDR_W.
//  o_stall_cache = o_mem_req & ~i_mem_valid (combinational), in every state.
//  FSM states:
//   RUN:
//    - i_mem_valid=0, i_pc_src_exec=1: latch target into redir_pc; ->MISS_REDIR.
//    - i_mem_valid=0, i_pc_src_exec=0: ->MISS.
//    - i_mem_valid=1, i_pc_src_exec=1: pc<=target (redirect overrides stall).
//    - i_mem_valid=1, redirect absent, ~i_stall_fetch: pc<=pc+4.
//    - i_mem_valid=1, otherwise: pc held.
//   MISS:
//    - pc held.
//    - i_pc_src_exec & ~i_mem_valid: latch target; ->MISS_REDIR.
//    - i_mem_valid: behaves as a RUN hit in the same cycle; ->RUN.
//    - i_mem_valid & i_pc_src_exec in the same cycle: pc<=target; ->RUN.
//   MISS_REDIR:
//    - pc (address) held.
//    - Further i_pc_src_exec overwrites redir_pc (last wins).
//    - On i_mem_valid: data discarded; IF/DEC loads bubble; pc<=redir_pc (or i_pc_target_exec
//      if i_pc_src_exec is also asserted); redir_pend<=0; ->RUN.
//  IF/DEC register priority: reset > i_flush_dec > MISS_REDIR discard > i_stall_dec > load.
//   - Load needs i_mem_valid: {rdata, pc, pc+4, valid=1}.
//   - Without i_mem_valid and not stalled: bubble (NOP_INSTR, valid=0).
//   - Flush and stall asserted together: flush wins.
//  One request outstanding max; cache must not return data while o_mem_req=0.
// TESTING
//  T1 reset: RESET_PC=0, hits every cycle -> o_mem_addr 0,4,8,...; o_valid_dec=1 from cycle 2.
//  T2 miss: hold i_mem_valid=0 3 cycles at addr 0x10 -> o_stall_cache=1 3 cycles, addr fixed
//     0x10; on valid, o_instr_dec=rdata, next addr 0x14.
//  T3 redirect during miss: miss at 0x20; pc_src_exec=1, target 0x100 in miss cycle 2; valid
//     cycle 4 -> o_valid_dec=0 (bubble), next addr 0x100.
//  T4 redirect on hit plus i_flush_dec: target 0x40 -> next addr 0x40; IF/DEC=NOP, valid 0.
//  T5 load-use stall: i_stall_fetch=i_stall_dec=1 one cycle on hit -> PC and IF/DEC held;
//     resume +4.
//  T6 async reset asserted mid-MISS_REDIR -> outputs at reset values immediately; fetch
//     restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a single blocking I-cache request and the IF/DEC pipeline register.
// A redirect that arrives during a miss is parked until the miss returns, then the stale word is dropped.
module fetch_unit #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_stall_fetch,
    input  logic               i_stall_dec,
    input  logic               i_flush_dec,
    input  logic               i_pc_src_exec,
    input  logic [ADDR_W-1:0]  i_pc_target_exec,
    output logic               o_mem_req,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_valid,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic               o_stall_cache,
    output logic [INSTR_W-1:0] o_instr_dec,
    output logic [ADDR_W-1:0]  o_pc_dec,
    output logic [ADDR_W-1:0]  o_pc_plus4_dec,
    output logic               o_valid_dec
);

    typedef enum logic [1:0] {RUN, MISS, MISS_REDIR} state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } ifdec_t;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               mem_req_q;
    logic               discard;
    ifdec_t             ifdec_q, ifdec_d;

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign o_mem_req     = mem_req_q;
    assign o_mem_addr    = pc_q;
    assign o_stall_cache = mem_req_q & ~i_mem_valid;

    // Pending-redirect state is encoded by MISS_REDIR; redir_pc only matters there.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            RUN, MISS: begin
                if (mem_req_q) begin
                    if (i_mem_valid) begin
                        state_d = RUN;
                        if (i_pc_src_exec)      pc_d = i_pc_target_exec;
                        else if (!i_stall_fetch) pc_d = pc_plus4;
                    end else if (i_pc_src_exec) begin
                        redir_pc_d = i_pc_target_exec;
                        state_d    = MISS_REDIR;
                    end else begin
                        state_d = MISS;
                    end
                end
            end
            MISS_REDIR: begin
                if (i_mem_valid) begin
                    pc_d    = i_pc_src_exec ? i_pc_target_exec : redir_pc_q;
                    state_d = RUN;
                end else if (i_pc_src_exec) begin
                    redir_pc_d = i_pc_target_exec;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // The word returned for a fetch that was redirected away is wrong-path: bubble it.
    assign discard = (state_q == MISS_REDIR) & i_mem_valid;

    always_comb begin
        ifdec_d = ifdec_q;
        if (i_flush_dec || discard) begin
            ifdec_d.instr = NOP_INSTR;
            ifdec_d.valid = 1'b0;
        end else if (!i_stall_dec) begin
            if (i_mem_valid && mem_req_q) begin
                ifdec_d.instr    = i_mem_rdata;
                ifdec_d.pc       = pc_q;
                ifdec_d.pc_plus4 = pc_plus4;
                ifdec_d.valid    = 1'b1;
            end else begin
                ifdec_d.instr = NOP_INSTR;
                ifdec_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            redir_pc_q <= '0;
            mem_req_q  <= 1'b0;
            ifdec_q    <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            mem_req_q  <= 1'b1;
            ifdec_q    <= ifdec_d;
        end
    end

    assign o_instr_dec    = ifdec_q.instr;
    assign o_pc_dec       = ifdec_q.pc;
    assign o_pc_plus4_dec = ifdec_q.pc_plus4;
    assign o_valid_dec    = ifdec_q.valid;

endmodule
